// File: rtl/boot_pkg.sv
// Boot loader shared definitions: FSM state encoding and the default
// word address whose payload is captured into a register rather than memory.
// No ports; the CSUM states only exist when BOOT_CHECKSUM_EN is defined.
package boot_pkg;

    localparam logic [15:0] MEM_MAP_ADDR_DEFAULT = 16'd30;

    typedef enum logic [3:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
`ifdef BOOT_CHECKSUM_EN
        CSUM_HI,
        CSUM_LO,
`endif
        DONE,
        ERROR
    } boot_state_e;

    // State entered once the last payload word has been stored.
`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_e IMAGE_END_ST = CSUM_HI;
`else
    localparam boot_state_e IMAGE_END_ST = DONE;
`endif

endpackage

// File: rtl/boot_loader_if.sv
// Boot loader bus bundle: UART byte stream in, memory write channel out,
// plus the captured map word and the CPU release / error status.
// slave = boot loader side, master = UART/memory controller side.
interface boot_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  mem_wr_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_ack;
    logic [DATA_WIDTH-1:0] mem_map_init_values;
    logic                  cpu_enable;
    logic                  boot_error;

    modport slave (
        input  rx_data, rx_valid, mem_wr_ack,
        output mem_wr_req, mem_addr, mem_wr_data, mem_map_init_values,
               cpu_enable, boot_error
    );

    modport master (
        output rx_data, rx_valid, mem_wr_ack,
        input  mem_wr_req, mem_addr, mem_wr_data, mem_map_init_values,
               cpu_enable, boot_error
    );
endinterface

// File: rtl/boot_byte_packer.sv
// Pairs UART bytes (high first) into 16-bit words, with a one-byte skid register.
// Latency: word_vld_o is combinational with the low byte (or skid byte) consumption.
// Backpressure: while stall_i a single byte is parked; a second one raises overrun_o.
// Ports: rx_data_i/rx_valid_i byte stream; accept_i = FSM consuming bytes;
// stall_i = FSM busy writing; hi_vld_o/word_vld_o/word_o/overrun_o to the FSM.
module boot_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        accept_i,
    input  logic        stall_i,
    output logic        hi_vld_o,
    output logic        word_vld_o,
    output logic [15:0] word_o,
    output logic        overrun_o
);
    logic [7:0] skid_q, skid_d;
    logic       skid_vld_q, skid_vld_d;
    logic       phase_q, phase_d;      // 0: expecting high byte, 1: expecting low byte
    logic [7:0] hi_q, hi_d;
    logic [7:0] cur_byte;
    logic       take;

    always_comb begin
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        overrun_o  = 1'b0;

        // A parked byte is always older than the one on the wire.
        take     = accept_i && (skid_vld_q || rx_valid_i);
        cur_byte = skid_vld_q ? skid_q : rx_data_i;

        if (stall_i) begin
            if (rx_valid_i) begin
                if (skid_vld_q) begin
                    overrun_o = 1'b1;
                end else begin
                    skid_d     = rx_data_i;
                    skid_vld_d = 1'b1;
                end
            end
        end else if (accept_i) begin
            // Draining the skid while a new byte lands: the new byte refills it.
            if (skid_vld_q) begin
                skid_vld_d = rx_valid_i;
                if (rx_valid_i) begin
                    skid_d = rx_data_i;
                end
            end
        end else begin
            skid_vld_d = 1'b0;
        end

        if (take) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = cur_byte;
            end
        end

        hi_vld_o   = take && !phase_q;
        word_vld_o = take && phase_q;
        word_o     = {hi_q, cur_byte};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q     <= 8'h00;
            skid_vld_q <= 1'b0;
            phase_q    <= 1'b0;
            hi_q       <= 8'h00;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
        end
    end
endmodule

// File: rtl/boot_loader.sv
// UART boot loader: length-prefixed word image written to memory, one word
// captured at MEM_MAP_ADDR, then the CPU is released. Optional trailing
// checksum compiled in with macro BOOT_CHECKSUM_EN.
// Latency: write request rises the cycle after a word's low byte; drops the cycle after ack.
// Backpressure: rx cannot stall; one byte is buffered during a write, a second is an overrun.
// Ports: clk, rst (async, active high); bus = boot_loader_if.slave.
module boot_loader
    import boot_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] MEM_MAP_ADDR = ADDR_WIDTH'(MEM_MAP_ADDR_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.slave  bus
);
    boot_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           left_q, left_d;       // payload words still to complete
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] map_q, map_d;
`ifdef BOOT_CHECKSUM_EN
    logic [15:0]           sum_q, sum_d;
`endif

    logic        accept, stall;
    logic        hi_vld, word_vld, overrun;
    logic [15:0] word;
    logic        word_done;

    assign stall  = (state_q == WRITE);
    assign accept = !((state_q == WRITE) || (state_q == DONE) || (state_q == ERROR));

    boot_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .rx_data_i  (bus.rx_data),
        .rx_valid_i (bus.rx_valid),
        .accept_i   (accept),
        .stall_i    (stall),
        .hi_vld_o   (hi_vld),
        .word_vld_o (word_vld),
        .word_o     (word),
        .overrun_o  (overrun)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        left_d    = left_q;
        wr_data_d = wr_data_q;
        map_d     = map_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        word_done = 1'b0;

        case (state_q)
            LEN_HI:  if (hi_vld) state_d = LEN_LO;
            LEN_LO: begin
                if (word_vld) begin
                    left_d  = word;
                    state_d = (word == 16'd0) ? IMAGE_END_ST : DATA_HI;
                end
            end
            DATA_HI: if (hi_vld) state_d = DATA_LO;
            DATA_LO: begin
                if (word_vld) begin
`ifdef BOOT_CHECKSUM_EN
                    sum_d = sum_q + word;
`endif
                    if (addr_q == MEM_MAP_ADDR) begin
                        // Captured locally; still consumes an address slot.
                        map_d     = DATA_WIDTH'(word);
                        word_done = 1'b1;
                    end else begin
                        wr_data_d = DATA_WIDTH'(word);
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                if (overrun) begin
                    state_d = ERROR;
                end else if (bus.mem_wr_ack) begin
                    word_done = 1'b1;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM_HI: if (hi_vld) state_d = CSUM_LO;
            CSUM_LO: begin
                if (word_vld) begin
                    state_d = (word == sum_q) ? DONE : ERROR;
                end
            end
`endif
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

        if (word_done) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            left_d  = left_q - 16'd1;
            state_d = (left_q == 16'd1) ? IMAGE_END_ST : DATA_HI;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LEN_HI;
            addr_q    <= '0;
            left_q    <= 16'd0;
            wr_data_q <= '0;
            map_q     <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q     <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            wr_data_q <= wr_data_d;
            map_q     <= map_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    // Status outputs are decoded from registered state, so reset clears them at once.
    assign bus.mem_wr_req          = (state_q == WRITE);
    assign bus.mem_addr            = addr_q;
    assign bus.mem_wr_data         = wr_data_q;
    assign bus.mem_map_init_values = map_q;
    assign bus.cpu_enable          = (state_q == DONE);
    assign bus.boot_error          = (state_q == ERROR);
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, memory word-address width.
REQ-002 Parameter DATA_WIDTH, default 16, memory word width.
REQ-003 Parameter MEM_MAP_ADDR, default 16'd30, word address that is captured to a register instead of being written to SDRAM.
REQ-004 clk  in  1  single system clock; all state on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rx_data  in  8  byte from UART receiver.
REQ-007 rx_valid  in  1  one-cycle strobe; rx_data valid. Cannot be stalled.
REQ-008 mem_wr_req  out  1  write request to memory controller; held until ack.
REQ-009 mem_addr  out  ADDR_WIDTH  write word address.
REQ-010 mem_wr_data  out  DATA_WIDTH  write word.
REQ-011 mem_wr_ack  in  1  one-cycle write-complete strobe from memory controller.
REQ-012 mem_map_init_values  out  DATA_WIDTH  word captured at MEM_MAP_ADDR.
REQ-013 cpu_enable  out  1  high once the image is fully loaded; releases CPU.
REQ-014 boot_error  out  1  sticky error flag.

Function
REQ-015 Stream format SHALL be: length N (16-bit word count, high byte first), then N words (high byte first), then the optional checksum (REQ-032).
REQ-016 States SHALL be LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM_HI, CSUM_LO, DONE, ERROR.
REQ-017 LEN_HI->LEN_LO->DATA_HI on rx_valid. From LEN_LO, N=0 SHALL go directly to the end-of-image state (REQ-021).
REQ-018 DATA_HI->DATA_LO on rx_valid. DATA_LO on rx_valid SHALL form {hi,lo}; if address != MEM_MAP_ADDR, go to WRITE; otherwise load mem_map_init_values in the same cycle and skip WRITE.
REQ-019 In WRITE, mem_wr_req SHALL be high and mem_addr/mem_wr_data stable. On mem_wr_ack, drop mem_wr_req the next cycle and increment the address.
REQ-020 Addresses SHALL start at 0 and increment by 1 per word, including the MEM_MAP_ADDR word. The address counter SHALL wrap from 2^ADDR_WIDTH-1 to 0 without error.
REQ-021 After word N completes, go to CSUM_HI if checksum is enabled, else to DONE.
REQ-022 In DONE, cpu_enable SHALL be 1 from the cycle after entry. All rx bytes SHALL be ignored until reset.
REQ-023 One-byte skid register: a byte arriving in WRITE SHALL be held and consumed as the DATA_HI byte when WRITE exits.
REQ-024 A second byte arriving while the skid register is full SHALL cause a transition to ERROR (overrun).
REQ-025 If rx_valid and mem_wr_ack occur in the same cycle, the ack SHALL complete the write and the byte SHALL enter the skid register (no overrun).
REQ-026 ERROR SHALL set boot_error=1, hold cpu_enable=0, deassert mem_wr_req, and remain in ERROR until reset.

Reset
REQ-027 On rst: state=LEN_HI; address, length, and skid register cleared.
REQ-028 On rst: mem_wr_req=0, mem_addr=0, mem_wr_data=0, mem_map_init_values=0, cpu_enable=0, boot_error=0.
REQ-029 An rst asserted during any state, including mid-WRITE, SHALL abort immediately. The memory controller SHALL treat a dropped request as cancelled.

Configuration
REQ-030 Macro BOOT_CHECKSUM_EN SHALL compile the checksum path in or out.
REQ-031 With BOOT_CHECKSUM_EN defined: maintain a 16-bit wrap-around sum of all N payload words, including the MEM_MAP_ADDR word and excluding the length.
REQ-032 With BOOT_CHECKSUM_EN defined: CSUM_HI->CSUM_LO; a match goes to DONE, a mismatch goes to ERROR.
REQ-033 Without BOOT_CHECKSUM_EN, the CSUM states and the sum register SHALL not exist, and no trailing word is expected.

Structure
REQ-034 Package boot_pkg SHALL hold the state enum and the default MEM_MAP_ADDR constant.
REQ-035 Sub-module boot_byte_packer SHALL assemble byte pairs into words (hi/lo toggle plus skid register) and present word_valid/word to the FSM.

Verification
REQ-036 Stream 00 03 12 34 AB CD 00 01 with immediate ack -> writes 0:1234, 1:ABCD, 2:0001; cpu_enable=1; boot_error=0.
REQ-037 N=40, word 30=BEEF -> no write at address 30; mem_map_init_values=BEEF; address 31 written with word 31.
REQ-038 Ack delayed 20 cycles, one byte arriving mid-WRITE -> byte buffered, next word correct. Two bytes mid-WRITE -> boot_error=1, cpu_enable stays 0.
REQ-039 BOOT_CHECKSUM_EN with stream 00 02 00 01 00 02 00 03 -> DONE. Same stream with checksum 00 04 -> ERROR.
REQ-040 rst pulsed mid-WRITE of word 5, then a full new image -> all outputs at reset values within the rst cycle, and the new image loads from address 0.
REQ-041 N=0 -> cpu_enable=1 with zero writes; bytes after DONE produce no mem_wr_req.
